// File: rtl/pc_parser_mw_pkg.sv
// pc_parser_mw shared package: route-code ranges,
// assembly sizing helper and FSM state type.
package pc_parser_mw_pkg;

  localparam logic [7:0] NOP_CODE = 8'hFF;

  typedef enum logic {
    S_IDLE,
    S_ASSEMBLE
  } state_e;

  function automatic int leaf_base();
    return 0;
  endfunction

  function automatic int reg_base(int nleaf);
    return leaf_base() + nleaf;
  endfunction

  function automatic int chan_base(int nleaf, int nreg);
    return reg_base(nleaf) + nreg;
  endfunction

  function automatic int words_per_bd(int nbd, int nchunk);
    return (nbd + nchunk - 1) / nchunk;
  endfunction

endpackage

// File: rtl/pc_parser_mw_if.sv
// Handshake bundle between host link, BD encoder
// and config channels of pc_parser_mw.
interface pc_parser_mw_if #(
  parameter int NPCin     = 32,
  parameter int NBDdata   = 40,
  parameter int Nleafcode = 6,
  parameter int Nconf     = 16,
  parameter int Nchan     = 4
);

  logic [NPCin-1:0]            PC_in_d;
  logic                        PC_in_v;
  logic                        PC_in_a;

  logic [Nleafcode-1:0]        BD_out_leaf_code;
  logic [NBDdata-1:0]          BD_out_payload;
  logic                        BD_out_v;
  logic                        BD_out_a;

  logic [Nchan-1:0][Nconf-1:0] conf_chan_d;
  logic [Nchan-1:0]            conf_chan_v;
  logic [Nchan-1:0]            conf_chan_a;

  modport slave (
    input  PC_in_d, PC_in_v,
    output PC_in_a,
    output BD_out_leaf_code, BD_out_payload,
    output BD_out_v,
    input  BD_out_a,
    output conf_chan_d, conf_chan_v,
    input  conf_chan_a
  );

  modport master (
    output PC_in_d, PC_in_v,
    input  PC_in_a,
    input  BD_out_leaf_code, BD_out_payload,
    input  BD_out_v,
    output BD_out_a,
    input  conf_chan_d, conf_chan_v,
    output conf_chan_a
  );

endinterface

// File: rtl/out_slot.sv
// One-entry valid/ack holding register; a load may
// land in the same cycle the held entry drains.
module out_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ld,
  input  logic [W-1:0] ld_d,
  input  logic         a,
  output logic         v,
  output logic [W-1:0] d,
  output logic         can_load
);

  assign can_load = !v || a;

  always_ff @(posedge clk) begin
    if (reset) begin
      v <= 1'b0;
      d <= '0;
    end else if (ld) begin
      v <= 1'b1;
      d <= ld_d;
    end else if (a) begin
      v <= 1'b0;
    end
  end

endmodule

// File: rtl/pc_parser_mw.sv
// Host-word parser: multi-chunk BD assembly, config
// register writes and config-channel token pushes.
module pc_parser_mw
  import pc_parser_mw_pkg::*;
#(
  parameter int NPCin     = 32,
  parameter int NBDdata   = 40,
  parameter int Nleaf     = 16,
  parameter int Nleafcode = 6,
  parameter int Nconf     = 16,
  parameter int Nreg      = 8,
  parameter int Nchan     = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  pc_parser_mw_if.slave              bus,
  input  logic [Nreg-1:0][Nconf-1:0] conf_reg_reset_vals,
  output logic [Nreg-1:0][Nconf-1:0] conf_reg_out,
  output logic [15:0]                err_count
);

  localparam int Nchunk = NPCin - 8;
  localparam int NW     = words_per_bd(NBDdata, Nchunk);
  localparam int IW     = (NW > 1) ? $clog2(NW) : 1;
  localparam int REG_BI = reg_base(Nleaf);
  localparam int CH_BI  = chan_base(Nleaf, Nreg);
  localparam int BDW    = Nleafcode + NBDdata;

  localparam logic [7:0] REG_B = 8'(REG_BI);
  localparam logic [7:0] CH_B  = 8'(CH_BI);
  localparam logic [7:0] CH_E  = 8'(CH_BI + Nchan);
  localparam logic [IW-1:0] LAST = IW'(NW - 1);

  logic [7:0]        code;
  logic [Nchunk-1:0] chunk;
  logic is_leaf, is_reg, is_chan, is_ill;
  logic fire, blocked, same, bd_need;

  state_e             state, state_n;
  logic [7:0]         cur, cur_n;
  logic [IW-1:0]      idx, idx_n;
  logic [NBDdata-1:0] acc, acc_n;
  logic               err_inc;

  logic           bd_ld, bd_can;
  logic [BDW-1:0] bd_ld_d, bd_d;

  logic [Nchan-1:0] ch_sel, ch_ld;
  logic             ch_can [Nchan];
  logic             ch_v   [Nchan];
  logic [Nconf-1:0] ch_d   [Nchan];

  assign code  = bus.PC_in_d[NPCin-1 -: 8];
  assign chunk = bus.PC_in_d[Nchunk-1:0];

  always_comb begin : classify
    is_leaf = code < REG_B;
    is_reg  = (code >= REG_B) && (code < CH_B);
    is_chan = (code >= CH_B) && (code < CH_E);
    is_ill  = !is_leaf && !is_reg && !is_chan
              && (code != NOP_CODE);
  end

  // Does this word complete a BD payload?
  always_comb begin : finality
    same = (state == S_ASSEMBLE) && (code == cur);
    if (same) bd_need = is_leaf && (idx == LAST);
    else      bd_need = is_leaf && (NW == 1);
  end

  always_comb begin : route
    blocked = bd_need && !bd_can;
    for (int c = 0; c < Nchan; c++) begin
      ch_sel[c] = is_chan && (code == 8'(CH_BI + c));
      if (ch_sel[c] && !ch_can[c]) blocked = 1'b1;
    end
  end

  assign bus.PC_in_a = !blocked;
  assign fire        = bus.PC_in_v && !blocked;
  assign ch_ld       = fire ? ch_sel : '0;

  always_comb begin : fsm_next
    state_n = state;
    cur_n   = cur;
    idx_n   = idx;
    acc_n   = acc;
    err_inc = 1'b0;
    bd_ld   = 1'b0;
    if (fire && is_leaf) begin
      // A different leaf aborts and restarts assembly
      if (!same) begin
        err_inc = (state == S_ASSEMBLE);
        acc_n   = '0;
        idx_n   = '0;
      end
      for (int i = 0; i < NBDdata; i++)
        if (i / Nchunk == int'(idx_n))
          acc_n[i] = chunk[i % Nchunk];
      if (bd_need) begin
        bd_ld   = 1'b1;
        state_n = S_IDLE;
        idx_n   = '0;
      end else begin
        state_n = S_ASSEMBLE;
        cur_n   = code;
        idx_n   = idx_n + 1'b1;
      end
    end
    if (fire && is_ill) err_inc = 1'b1;
    bd_ld_d = {code[Nleafcode-1:0], acc_n};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cur       <= '0;
      idx       <= '0;
      acc       <= '0;
      err_count <= '0;
    end else begin
      state <= state_n;
      cur   <= cur_n;
      idx   <= idx_n;
      acc   <= acc_n;
      if (err_inc && err_count != 16'hFFFF)
        err_count <= err_count + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      conf_reg_out <= conf_reg_reset_vals;
    end else if (fire && is_reg) begin
      for (int r = 0; r < Nreg; r++)
        if (code == 8'(REG_BI + r))
          conf_reg_out[r] <= chunk[Nconf-1:0];
    end
  end

  out_slot #(.W(BDW)) u_bd_slot (
    .clk      (clk),
    .reset    (reset),
    .ld       (bd_ld),
    .ld_d     (bd_ld_d),
    .a        (bus.BD_out_a),
    .v        (bus.BD_out_v),
    .d        (bd_d),
    .can_load (bd_can)
  );

  assign bus.BD_out_leaf_code = bd_d[BDW-1 -: Nleafcode];
  assign bus.BD_out_payload   = bd_d[NBDdata-1:0];

  for (genvar c = 0; c < Nchan; c++) begin : g_chan
    out_slot #(.W(Nconf)) u_ch_slot (
      .clk      (clk),
      .reset    (reset),
      .ld       (ch_ld[c]),
      .ld_d     (chunk[Nconf-1:0]),
      .a        (bus.conf_chan_a[c]),
      .v        (ch_v[c]),
      .d        (ch_d[c]),
      .can_load (ch_can[c])
    );
  end

  always_comb begin : chan_out
    for (int c = 0; c < Nchan; c++) begin
      bus.conf_chan_v[c] = ch_v[c];
      bus.conf_chan_d[c] = ch_d[c];
    end
  end

endmodule

// File: tb/tb_pc_parser_mw.sv
// Bench for pc_parser_mw: directed scenarios plus random
// traffic against a queue-based reference model.
module tb_pc_parser_mw;

  localparam int NPCin     = 32;
  localparam int NBDdata   = 40;
  localparam int Nleaf     = 16;
  localparam int Nleafcode = 6;
  localparam int Nconf     = 16;
  localparam int Nreg      = 8;
  localparam int Nchan     = 4;
  localparam int Nchunk    = NPCin - 8;
  localparam int NW        = (NBDdata + Nchunk - 1) / Nchunk;

  logic clk = 1'b0;
  logic reset;
  logic [Nreg-1:0][Nconf-1:0] conf_reg_reset_vals;
  logic [Nreg-1:0][Nconf-1:0] conf_reg_out;
  logic [15:0] err_count;

  always #5 clk = ~clk;

  pc_parser_mw_if #(
    .NPCin(NPCin), .NBDdata(NBDdata),
    .Nleafcode(Nleafcode), .Nconf(Nconf), .Nchan(Nchan)
  ) bus ();

  pc_parser_mw #(
    .NPCin(NPCin), .NBDdata(NBDdata), .Nleaf(Nleaf),
    .Nleafcode(Nleafcode), .Nconf(Nconf),
    .Nreg(Nreg), .Nchan(Nchan)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .bus                 (bus.slave),
    .conf_reg_reset_vals (conf_reg_reset_vals),
    .conf_reg_out        (conf_reg_out),
    .err_count           (err_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(string tag, logic [63:0] got,
                       logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [45:0] bd_q [$];
  logic [15:0] chq [Nchan][$];
  logic [15:0] m_reg [Nreg];
  int          m_err;
  bit          part_on;
  int          part_leaf;
  logic [23:0] part [$];
  logic        last_a;

  function automatic logic [39:0] join_chunks();
    logic [63:0] p = '0;
    for (int i = 0; i < part.size(); i++)
      p |= 64'(part[i]) << (Nchunk * i);
    return p[39:0];
  endfunction

  function automatic void bump_err();
    if (m_err < 65535) m_err++;
  endfunction

  function automatic void model_word(logic [31:0] d);
    int code = int'(d[31:24]);
    logic [23:0] ch = d[23:0];
    if (code == 255) return;
    if (code < Nleaf) begin
      if (part_on && part_leaf != code) begin
        bump_err();
        part_on = 0;
        part.delete();
      end
      part_on   = 1;
      part_leaf = code;
      part.push_back(ch);
      if (part.size() == NW) begin
        bd_q.push_back({6'(code), join_chunks()});
        part_on = 0;
        part.delete();
      end
    end else if (code < Nleaf + Nreg) begin
      m_reg[code - Nleaf] = ch[15:0];
    end else if (code < Nleaf + Nreg + Nchan) begin
      chq[code - Nleaf - Nreg].push_back(ch[15:0]);
    end else begin
      bump_err();
    end
  endfunction

  function automatic bit exp_ready(logic [31:0] d, bit bda,
                                   logic [3:0] cha);
    int code = int'(d[31:24]);
    bit fin;
    if (code < Nleaf) begin
      if (part_on && part_leaf == code)
        fin = (part.size() + 1 == NW);
      else
        fin = (NW == 1);
      if (fin && bd_q.size() != 0 && !bda) return 0;
    end else if (code >= Nleaf + Nreg &&
                 code < Nleaf + Nreg + Nchan) begin
      if (chq[code - Nleaf - Nreg].size() != 0 &&
          !cha[code - Nleaf - Nreg]) return 0;
    end
    return 1;
  endfunction

  task automatic check_regs();
    for (int r = 0; r < Nreg; r++)
      check($sformatf("reg%0d", r), conf_reg_out[r], m_reg[r]);
    check("err_count", err_count, m_err);
  endtask

  // One clock: drive, check pre-edge, advance model, check post-edge
  task automatic step(bit v, logic [31:0] d, bit bda,
                      logic [3:0] cha);
    bit ea;
    bus.PC_in_v     = v;
    bus.PC_in_d     = d;
    bus.BD_out_a    = bda;
    bus.conf_chan_a = cha;
    #3;
    ea = exp_ready(d, bda, cha);
    last_a = bus.PC_in_a;
    if (v) check("pc_in_a", bus.PC_in_a, ea);
    check("bd_v", bus.BD_out_v, bd_q.size() != 0);
    if (bd_q.size() != 0) begin
      check("bd_leaf", bus.BD_out_leaf_code, bd_q[0][45:40]);
      check("bd_payload", bus.BD_out_payload, bd_q[0][39:0]);
    end
    for (int c = 0; c < Nchan; c++) begin
      check($sformatf("ch%0d_v", c), bus.conf_chan_v[c],
            chq[c].size() != 0);
      if (chq[c].size() != 0)
        check($sformatf("ch%0d_d", c), bus.conf_chan_d[c],
              chq[c][0]);
    end
    if (bd_q.size() != 0 && bda) void'(bd_q.pop_front());
    for (int c = 0; c < Nchan; c++)
      if (chq[c].size() != 0 && cha[c]) void'(chq[c].pop_front());
    if (v && ea) model_word(d);
    @(posedge clk);
    #1;
    check_regs();
  endtask

  task automatic do_reset();
    reset           = 1'b1;
    bus.PC_in_v     = 1'b0;
    bus.PC_in_d     = '0;
    bus.BD_out_a    = 1'b0;
    bus.conf_chan_a = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    bd_q.delete();
    for (int c = 0; c < Nchan; c++) chq[c].delete();
    for (int r = 0; r < Nreg; r++) m_reg[r] = conf_reg_reset_vals[r];
    m_err   = 0;
    part_on = 0;
    part.delete();
    check("rst_bd_v", bus.BD_out_v, 0);
    check("rst_bd_payload", bus.BD_out_payload, 0);
    check("rst_ch_v", bus.conf_chan_v, 0);
    check("rst_ch_d", bus.conf_chan_d, 0);
    check_regs();
  endtask

  initial begin
    logic [31:0] w;
    int r;
    reset = 1'b1;
    bus.PC_in_v = 1'b0;
    bus.PC_in_d = '0;
    bus.BD_out_a = 1'b0;
    bus.conf_chan_a = '0;
    for (int i = 0; i < Nreg; i++)
      conf_reg_reset_vals[i] = 16'($urandom);
    @(posedge clk);
    #1;
    do_reset();

    // Two-word BD assembly
    step(1, 32'h0300BEEF, 1, 4'hF);
    check("two_word_v_early", bus.BD_out_v, 0);
    step(1, 32'h0300ABCD, 1, 4'hF);
    check("two_word_v", bus.BD_out_v, 1);
    check("two_word_leaf", bus.BD_out_leaf_code, 3);
    check("two_word_payload", bus.BD_out_payload, 40'hABCD00BEEF);
    check("two_word_err", err_count, 0);
    step(0, 0, 1, 4'hF);

    // Aborted assembly
    do_reset();
    step(1, 32'h03000001, 1, 4'hF);
    step(1, 32'h05000002, 1, 4'hF);
    check("abort_err", err_count, 1);
    check("abort_no_bd", bus.BD_out_v, 0);
    step(1, 32'h05000003, 1, 4'hF);
    check("abort_leaf", bus.BD_out_leaf_code, 5);
    check("abort_payload", bus.BD_out_payload, 40'h0003000002);
    step(0, 0, 1, 4'hF);

    // Register write interleaved with assembly
    do_reset();
    step(1, 32'h04111111, 1, 4'hF);
    step(1, 32'h1200CAFE, 1, 4'hF);
    check("ilv_reg2", conf_reg_out[2], 16'hCAFE);
    step(1, 32'h04222222, 1, 4'hF);
    check("ilv_leaf", bus.BD_out_leaf_code, 4);
    check("ilv_payload", bus.BD_out_payload, 40'h2222111111);
    step(0, 0, 1, 4'hF);

    // Channel backpressure and same-edge reload
    do_reset();
    step(1, 32'h19000AAA, 1, 4'h0);
    check("bp_v1", bus.conf_chan_v[1], 1);
    check("bp_d1", bus.conf_chan_d[1], 16'h0AAA);
    step(1, 32'h19000BBB, 1, 4'h0);
    check("bp_stall", last_a, 0);
    check("bp_hold", bus.conf_chan_d[1], 16'h0AAA);
    step(1, 32'h19000BBB, 1, 4'h2);
    check("bp_accept", last_a, 1);
    check("bp_reload_v", bus.conf_chan_v[1], 1);
    check("bp_reload_d", bus.conf_chan_d[1], 16'h0BBB);
    step(0, 0, 1, 4'hF);

    // NOP and illegal codes
    do_reset();
    step(1, 32'hFF123456, 1, 4'hF);
    step(1, 32'h40000000, 1, 4'hF);
    check("ill_err", err_count, 1);
    check("ill_bd", bus.BD_out_v, 0);
    check("ill_ch", bus.conf_chan_v, 0);

    // Reset in the middle of an assembly
    step(1, 32'h0100000F, 1, 4'hF);
    do_reset();
    step(1, 32'h01000010, 1, 4'hF);
    check("rst_mid_no_bd", bus.BD_out_v, 0);
    check("rst_mid_err", err_count, 0);
    step(1, 32'h01000011, 1, 4'hF);
    check("rst_mid_bd", bus.BD_out_v, 1);
    check("rst_mid_payload", bus.BD_out_payload, 40'h0011000010);
    step(0, 0, 1, 4'hF);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 9);
      w = $urandom;
      if (r <= 4)      w[31:24] = 8'($urandom_range(0, 3));
      else if (r == 5) w[31:24] = 8'($urandom_range(16, 23));
      else if (r == 6) w[31:24] = 8'($urandom_range(24, 27));
      else if (r == 7) w[31:24] = 8'hFF;
      else if (r == 8) w[31:24] = 8'($urandom_range(28, 254));
      else             w[31:24] = 8'($urandom_range(0, 15));
      if (n == 1500) do_reset();
      step($urandom_range(0, 3) != 0, w,
           $urandom_range(0, 2) != 0, 4'($urandom));
    end
    for (int n = 0; n < 4; n++) step(0, 0, 1, 4'hF);
    check("drain_bd", bd_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
